// File: rtl/multicore_mem_arbiter_if.sv
// multicore_mem_arbiter_if: bundled picorv32 native memory buses of all cores
//   core_valid/addr/wdata/wstrb : per-core request, core i in slice i
//   core_ready                  : per-core one-hot ready pulse
//   core_rdata                  : read data broadcast to all cores
interface multicore_mem_arbiter_if #(
  parameter int NUM_CORES = 4
);
  logic [NUM_CORES-1:0] core_valid;
  logic [NUM_CORES-1:0] core_ready;
  logic [32*NUM_CORES-1:0] core_addr;
  logic [32*NUM_CORES-1:0] core_wdata;
  logic [4*NUM_CORES-1:0] core_wstrb;
  logic [31:0] core_rdata;
  modport master (
    output core_valid, core_addr, core_wdata, core_wstrb,
    input core_ready, core_rdata
  );
  modport slave (
    input core_valid, core_addr, core_wdata, core_wstrb,
    output core_ready, core_rdata
  );
endinterface

// File: rtl/multicore_mem_arbiter.sv
// multicore_mem_arbiter: round-robin shared RAM/LED/UART/spinlock/core-id interconnect
//   clk, resetn : clock, synchronous active-low reset
//   bus         : slave side of the per-core native memory buses
//   leds        : LED register (byte-strobed writes)
//   tx_data     : UART byte, tx_send one-cycle send pulse, tx_ready UART idle
module multicore_mem_arbiter #(
  parameter int NUM_CORES = 4,
  parameter int MEM_WORDS = 2048,
  parameter int NUM_LOCKS = 4,
  parameter INIT_FILE = "firmware.hex"
) (
  input  logic clk,
  input  logic resetn,
  multicore_mem_arbiter_if.slave bus,
  output logic [31:0] leds,
  output logic [7:0] tx_data,
  output logic tx_send,
  input  logic tx_ready
);
  localparam int GW = NUM_CORES > 1 ? $clog2(NUM_CORES) : 1;
  localparam int AW = $clog2(MEM_WORDS);
  localparam int LW = $clog2(NUM_LOCKS);
  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
  state_t state_q, state_d;
  logic [GW-1:0] grant_q, grant_d;
  logic [31:0] addr_q, addr_d, wdata_q, wdata_d, rdata_q, rdata_d, leds_q, leds_d;
  logic [3:0] wstrb_q, wstrb_d;
  logic [7:0] tx_data_q, tx_data_d;
  logic tx_send_q, tx_send_d;
  logic [NUM_LOCKS-1:0] held_q, held_d;
  logic [NUM_LOCKS-1:0][GW-1:0] owner_q, owner_d;
  logic [31:0] mem [MEM_WORDS];
  logic [31:0] ram_rd;
  logic ram_we, found, wr;
  logic [AW-1:0] idx;
  logic [LW-1:0] lidx;
  logic unused_addr;
  int c;
  assign wr = |wstrb_q;
  assign idx = addr_q[AW+1:2];
  assign lidx = addr_q[LW+1:2];
  assign unused_addr = ^addr_q;
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    addr_d = addr_q;
    wdata_d = wdata_q;
    wstrb_d = wstrb_q;
    rdata_d = rdata_q;
    leds_d = leds_q;
    tx_data_d = tx_data_q;
    tx_send_d = 1'b0;
    held_d = held_q;
    owner_d = owner_q;
    ram_we = 1'b0;
    found = 1'b0;
    c = 0;
    case (state_q)
      IDLE: begin
        // grant_q doubles as last_grant: search starts just after it
        for (int i = 1; i <= NUM_CORES; i++) begin
          c = (int'(grant_q) + i) % NUM_CORES;
          if (!found && bus.core_valid[c]) begin
            found = 1'b1;
            grant_d = GW'(c);
            addr_d = bus.core_addr[32*c +: 32];
            wdata_d = bus.core_wdata[32*c +: 32];
            wstrb_d = bus.core_wstrb[4*c +: 4];
          end
        end
        state_d = found ? ACCESS : IDLE;
      end
      ACCESS: begin
        state_d = RESP;
        rdata_d = 32'd0;
        case (addr_q[31:28])
          4'h0: ram_we = wr;
          4'h1: begin
            for (int b = 0; b < 4; b++)
              leds_d[8*b +: 8] = wstrb_q[b] ? wdata_q[8*b +: 8] : leds_q[8*b +: 8];
            rdata_d = leds_q;
          end
          4'h2: begin
            rdata_d = {31'd0, tx_ready};
            // a write stalls here until the UART is idle
            state_d = wr && !tx_ready ? ACCESS : RESP;
            tx_send_d = wr && tx_ready;
            tx_data_d = wr && tx_ready ? wdata_q[7:0] : tx_data_q;
          end
          4'h3: begin
            if (wr) begin
              if (held_q[lidx] && owner_q[lidx] == grant_q) held_d[lidx] = 1'b0;
            end else begin
              rdata_d = {31'd0, held_q[lidx]};
              held_d[lidx] = 1'b1;
              if (!held_q[lidx]) owner_d[lidx] = grant_q;
            end
          end
          4'h4: rdata_d = 32'(grant_q);
          default: ;
        endcase
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= IDLE;
      grant_q <= GW'(NUM_CORES - 1);
      addr_q <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
      rdata_q <= '0;
      leds_q <= '0;
      tx_data_q <= '0;
      tx_send_q <= 1'b0;
      held_q <= '0;
      owner_q <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      addr_q <= addr_d;
      wdata_q <= wdata_d;
      wstrb_q <= wstrb_d;
      rdata_q <= rdata_d;
      leds_q <= leds_d;
      tx_data_q <= tx_data_d;
      tx_send_q <= tx_send_d;
      held_q <= held_d;
      owner_q <= owner_d;
    end
  end
  // RAM keeps its contents across reset; a write is dropped if reset hits its commit edge
  always_ff @(posedge clk) begin
    ram_rd <= mem[idx];
    if (ram_we && resetn)
      for (int b = 0; b < 4; b++)
        if (wstrb_q[b]) mem[idx][8*b +: 8] <= wdata_q[8*b +: 8];
  end
  assign bus.core_ready = state_q == RESP ? NUM_CORES'(1) << grant_q : '0;
  assign bus.core_rdata = state_q == RESP && addr_q[31:28] == 4'h0 ? ram_rd : rdata_q;
  assign leds = leds_q;
  assign tx_data = tx_data_q;
  assign tx_send = tx_send_q;
endmodule

// File: tb/tb_multicore_mem_arbiter.sv
// tb_multicore_mem_arbiter: scoreboard bench for the multicore memory arbiter
module tb_multicore_mem_arbiter;
  logic clk = 1'b0;
  logic resetn;
  logic tx_ready;
  logic [31:0] leds;
  logic [7:0] tx_data;
  logic tx_send;
  int total = 0, bad = 0, tx_cnt = 0, stray = 0;
  logic [7:0] tx_cap = '0;
  typedef struct {int core; logic [31:0] data; bit cmp; int lat;} exp_t;
  exp_t exp_q[$];
  multicore_mem_arbiter_if #(.NUM_CORES(4)) bus();
  multicore_mem_arbiter #(.NUM_CORES(4), .MEM_WORDS(2048), .NUM_LOCKS(4), .INIT_FILE("")) dut (
    .clk(clk), .resetn(resetn), .bus(bus), .leds(leds),
    .tx_data(tx_data), .tx_send(tx_send), .tx_ready(tx_ready)
  );
  always #5 clk = ~clk;
  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic push(int c, logic [31:0] d, bit cmp, int lat);
    exp_t e;
    e.core = c;
    e.data = d;
    e.cmp = cmp;
    e.lat = lat;
    exp_q.push_back(e);
  endtask
  task automatic issue(int c, logic [31:0] a, logic [31:0] d, logic [3:0] s);
    bus.core_addr[32*c +: 32] = a;
    bus.core_wdata[32*c +: 32] = d;
    bus.core_wstrb[4*c +: 4] = s;
    bus.core_valid[c] = 1'b1;
  endtask
  task automatic req(int c, logic [31:0] a, logic [31:0] d, logic [3:0] s,
                     logic [31:0] e, bit cmp, int lat);
    issue(c, a, d, s);
    push(c, e, cmp, lat);
  endtask
  // pop one expectation per ready pulse; a core keeps valid while it still has entries queued
  task automatic drain();
    int cyc, idle, last_at;
    bit more;
    exp_t e;
    cyc = 0;
    idle = 0;
    last_at = 0;
    while ((exp_q.size() != 0 || idle < 4) && cyc < 300) begin
      @(negedge clk);
      cyc++;
      if (tx_send) begin
        tx_cnt++;
        tx_cap = tx_data;
      end
      if (exp_q.size() == 0) idle++;
      if (bus.core_ready != '0) begin
        if (exp_q.size() == 0) chk("spurious_ready", 32'(bus.core_ready), 0);
        else begin
          e = exp_q.pop_front();
          chk("ready_core", 32'(bus.core_ready), 32'(1) << e.core);
          if (e.cmp) chk("rdata", bus.core_rdata, e.data);
          if (e.lat >= 0) chk("latency", cyc - last_at, e.lat);
          last_at = cyc;
          more = 1'b0;
          foreach (exp_q[k]) if (exp_q[k].core == e.core) more = 1'b1;
          if (!more) bus.core_valid[e.core] = 1'b0;
        end
      end
    end
    if (exp_q.size() != 0) begin
      chk("timeout_pending", exp_q.size(), 0);
      exp_q.delete();
      bus.core_valid = '0;
    end
  endtask
  initial begin
    resetn = 1'b0;
    tx_ready = 1'b1;
    bus.core_valid = '0;
    bus.core_addr = '0;
    bus.core_wdata = '0;
    bus.core_wstrb = '0;
    repeat (3) @(negedge clk);
    chk("rst_ready", 32'(bus.core_ready), 0);
    chk("rst_rdata", bus.core_rdata, 0);
    chk("rst_leds", leds, 0);
    chk("rst_tx_send", 32'(tx_send), 0);
    chk("rst_tx_data", 32'(tx_data), 0);
    resetn = 1'b1;
    req(0, 32'h40, 32'h12345678, 4'hF, 0, 0, 2);
    drain();
    req(0, 32'h40, 0, 4'h0, 32'h12345678, 1, 2);
    drain();
    req(0, 32'h40, 32'hAB000000, 4'h8, 0, 0, 2);
    drain();
    req(0, 32'h40, 0, 4'h0, 32'hAB345678, 1, 2);
    drain();
    req(0, 32'h2040, 0, 4'h0, 32'hAB345678, 1, 2);
    drain();
    for (int i = 0; i < 4; i++) begin
      req(3, 32'h100 + 4*i, 32'hC0DE0000 + i, 4'hF, 0, 0, 2);
      drain();
    end
    for (int i = 0; i < 4; i++) req(i, 32'h100 + 4*i, 0, 4'h0, 32'hC0DE0000 + i, 1, i == 0 ? 2 : 3);
    drain();
    req(1, 32'h104, 0, 4'h0, 32'hC0DE0001, 1, 2);
    req(3, 32'h10C, 0, 4'h0, 32'hC0DE0003, 1, 3);
    push(1, 32'hC0DE0001, 1, 3);
    push(3, 32'hC0DE0003, 1, 3);
    drain();
    req(2, 32'h30000004, 0, 4'h0, 0, 1, 2);
    drain();
    req(0, 32'h30000004, 0, 4'h0, 1, 1, 2);
    drain();
    req(0, 32'h30000004, 0, 4'hF, 0, 0, 2);
    drain();
    req(1, 32'h30000004, 0, 4'h0, 1, 1, 2);
    drain();
    req(2, 32'h30000004, 0, 4'hF, 0, 0, 2);
    drain();
    req(0, 32'h30000004, 0, 4'h0, 0, 1, 2);
    drain();
    req(0, 32'h30000004, 0, 4'hF, 0, 0, 2);
    drain();
    req(2, 32'h10000000, 32'h11223344, 4'hF, 0, 0, 2);
    drain();
    chk("leds_full", leds, 32'h11223344);
    req(2, 32'h10000000, 32'h0000AA00, 4'b0010, 0, 0, 2);
    drain();
    chk("leds_byte", leds, 32'h1122AA44);
    req(1, 32'h10000000, 0, 4'h0, 32'h1122AA44, 1, 2);
    drain();
    req(1, 32'h50000000, 0, 4'h0, 0, 1, 2);
    drain();
    req(2, 32'h40000000, 0, 4'h0, 2, 1, 2);
    drain();
    tx_ready = 1'b0;
    tx_cnt = 0;
    stray = 0;
    req(1, 32'h20000000, 32'h41, 4'h1, 0, 0, -1);
    repeat (8) begin
      @(negedge clk);
      if (bus.core_ready != '0 || tx_send) stray++;
    end
    chk("uart_stall", stray, 0);
    tx_ready = 1'b1;
    drain();
    chk("uart_send_cnt", tx_cnt, 1);
    chk("uart_send_data", 32'(tx_cap), 32'h41);
    tx_ready = 1'b0;
    req(3, 32'h20000000, 0, 4'h0, 0, 1, 2);
    drain();
    tx_ready = 1'b1;
    req(3, 32'h20000000, 0, 4'h0, 1, 1, 2);
    drain();
    req(2, 32'h30000000, 0, 4'h0, 0, 1, 2);
    drain();
    tx_ready = 1'b0;
    tx_cnt = 0;
    stray = 0;
    issue(0, 32'h20000000, 32'h55, 4'h1);
    repeat (4) @(negedge clk);
    resetn = 1'b0;
    bus.core_valid = '0;
    repeat (3) begin
      @(negedge clk);
      if (bus.core_ready != '0) stray++;
      if (tx_send) tx_cnt++;
    end
    chk("rst_mid_ready", stray, 0);
    chk("rst_mid_leds", leds, 0);
    chk("rst_mid_rdata", bus.core_rdata, 0);
    chk("rst_mid_tx_data", 32'(tx_data), 0);
    resetn = 1'b1;
    tx_ready = 1'b1;
    req(0, 32'h30000000, 0, 4'h0, 0, 1, 2);
    req(3, 32'h40000000, 0, 4'h0, 3, 1, 3);
    drain();
    chk("rst_mid_tx_send", tx_cnt, 0);
    req(1, 32'h40, 0, 4'h0, 32'hAB345678, 1, 2);
    drain();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
